// File: rtl/i2c_byte_writer.sv
// Single-byte I2C write controller: START, address+W, ACK, data, ACK, STOP
// on open-drain SCL/SDA, with SCL clock stretching during bit and ACK phases.
module i2c_byte_writer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       nack,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ACK1,
      DATA,
      ACK2,
      STOP
   } state_t;

   state_t           state_q, state_n;
   logic [1:0]       quarter_q, quarter_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic [2:0]       bit_q, bit_n;
   logic [7:0]       shift_q, shift_n;
   logic [7:0]       data_q, data_n;
   logic             busy_n, done_n, nack_n;
   logic             scl_oe_n, sda_oe_n, ready_n;
   logic             stretch_hold;
   logic             phase_end;

   // State and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         quarter_q <= 2'd0;
         div_q     <= '0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         data_q    <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
         cmd_ready <= 1'b1;
      end else begin
         state_q   <= state_n;
         quarter_q <= quarter_n;
         div_q     <= div_n;
         bit_q     <= bit_n;
         shift_q   <= shift_n;
         data_q    <= data_n;
         busy      <= busy_n;
         done      <= done_n;
         nack      <= nack_n;
         scl_oe    <= scl_oe_n;
         sda_oe    <= sda_oe_n;
         cmd_ready <= ready_n;
      end
   end

   // Next-state, timing base and line drive
   always_comb begin
      state_n      = state_q;
      quarter_n    = quarter_q;
      div_n        = div_q;
      bit_n        = bit_q;
      shift_n      = shift_q;
      data_n       = data_q;
      busy_n       = busy;
      done_n       = 1'b0;
      nack_n       = nack;
      stretch_hold = 1'b0;
      phase_end    = 1'b0;
      scl_oe_n     = 1'b0;
      sda_oe_n     = 1'b0;

      if (state_q == IDLE) begin
         if (cmd_valid) begin
            state_n   = START;
            quarter_n = 2'd0;
            div_n     = '0;
            bit_n     = 3'd0;
            shift_n   = {cmd_addr, 1'b0};
            data_n    = cmd_data;
            nack_n    = 1'b0;
            busy_n    = 1'b1;
         end
      end else begin
         // A target holding SCL low during the high half freezes the divider
         stretch_hold = (state_q inside {ADDR, ACK1, DATA, ACK2}) &&
                        quarter_q[1] && !scl_in;
         if (!stretch_hold) begin
            if (div_q == DIV_LAST) begin
               div_n     = '0;
               quarter_n = quarter_q + 2'd1;
               phase_end = (quarter_q == 2'd3);
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end

         if (phase_end) begin
            case (state_q)
               START: state_n = ADDR;
               ADDR: begin
                  shift_n = {shift_q[6:0], 1'b0};
                  bit_n   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_n = ACK1;
               end
               ACK1: begin
                  if (sda_in) begin
                     nack_n  = 1'b1;
                     state_n = STOP;
                  end else begin
                     state_n = DATA;
                     shift_n = data_q;
                     bit_n   = 3'd0;
                  end
               end
               DATA: begin
                  shift_n = {shift_q[6:0], 1'b0};
                  bit_n   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_n = ACK2;
               end
               ACK2: begin
                  if (sda_in) nack_n = 1'b1;
                  state_n = STOP;
               end
               STOP: begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
               default: state_n = IDLE;
            endcase
         end
      end

      // Line levels follow the state/quarter being entered so they switch on the same edge
      case (state_n)
         START: sda_oe_n = quarter_n[1];
         ADDR, DATA: begin
            scl_oe_n = ~quarter_n[1];
            sda_oe_n = ~shift_n[7];
         end
         ACK1, ACK2: scl_oe_n = ~quarter_n[1];
         STOP: begin
            scl_oe_n = ~quarter_n[1];
            sda_oe_n = (quarter_n != 2'd3);
         end
         default: begin
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b0;
         end
      endcase

      ready_n = (state_n == IDLE);
   end

endmodule
